// File: rtl/imu_bracket_finder_pkg.sv
// Shared types and constants for the IMU bracket finder.
package imu_sync_pkg;

  localparam int unsigned SAMPLE_W = 128;
  localparam int unsigned TS_W     = 64;

  typedef struct packed {
    logic signed [15:0] ax;
    logic signed [15:0] ay;
    logic signed [15:0] az;
    logic signed [15:0] gx;
  } imu_data_t;

  typedef struct packed {
    imu_data_t        payload;
    logic [TS_W-1:0]  ts;
  } imu_sample_t;

  typedef enum logic [1:0] {StIdle, StScan, StEmit} bf_state_e;

endpackage

// File: rtl/imu_bracket_finder_if.sv
// Sample/request/result bundle between the fusion side and the bracket finder.
interface imu_bracket_finder_if;
  import imu_sync_pkg::*;

  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                sample_ready;
  logic                req_valid;
  logic [TS_W-1:0]     req_time;
  logic                req_ready;
  logic [SAMPLE_W-1:0] data_out;
  logic                valid_out;
  logic [SAMPLE_W-1:0] prev_out;
  logic                prev_valid_out;
  logic                miss_out;
  logic [15:0]         drop_cnt;

  modport master (
    output sample_in, sample_valid, req_valid, req_time,
    input  sample_ready, req_ready, data_out, valid_out, prev_out, prev_valid_out, miss_out,
           drop_cnt
  );

  modport slave (
    input  sample_in, sample_valid, req_valid, req_time,
    output sample_ready, req_ready, data_out, valid_out, prev_out, prev_valid_out, miss_out,
           drop_cnt
  );

endinterface

// File: rtl/imu_sample_ring.sv
// Ring of the most recent samples with a strictly-increasing timestamp guard.
// One read port addressed by age (0 = newest); newest ts and oldest sample are status taps.
module imu_sample_ring
  import imu_sync_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  imu_sample_t     wr_data,
  output logic            wr_ok,
  input  logic [AW-1:0]   rd_age,
  output imu_sample_t     rd_data,
  output logic [TS_W-1:0] newest_ts,
  output imu_sample_t     oldest,
  output logic [AW:0]     cnt,
  output logic [15:0]     drop_cnt
);

  imu_sample_t   mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW:0]   cnt_q;
  logic [15:0]   drop_q;
  logic [AW-1:0] newest_idx, oldest_idx, rd_idx;
  logic          stale;

  // Age-to-slot translation; all indices wrap naturally because DEPTH is a power of two.
  always_comb begin
    newest_idx = wp_q - AW'(1);
    oldest_idx = wp_q - cnt_q[AW-1:0];
    rd_idx     = newest_idx - rd_age;
  end

  assign rd_data   = mem_q[rd_idx];
  assign newest_ts = mem_q[newest_idx].ts;
  assign oldest    = mem_q[oldest_idx];
  assign stale     = (cnt_q != '0) && (wr_data.ts <= newest_ts);
  assign wr_ok     = wr_en && !stale;
  assign cnt       = cnt_q;
  assign drop_cnt  = drop_q;

  // Write pointer, saturating occupancy and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
    end else if (wr_en) begin
      if (stale) begin
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end else begin
        wp_q <= wp_q + AW'(1);
        if (cnt_q != (AW+1)'(DEPTH)) cnt_q <= cnt_q + (AW+1)'(1);
      end
    end
  end

  // Storage has no reset: entries beyond cnt are never looked at.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wp_q] <= wr_data;
  end

endmodule

// File: rtl/imu_bracket_finder.sv
// Finds the two consecutive stored samples bracketing a requested time.
// A one-entry skid keeps the ring frozen while a search is in flight.
module imu_bracket_finder
  import imu_sync_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  imu_bracket_finder_if.slave bus
);

  bf_state_e       state_q;
  logic [AW-1:0]   j_q, last_j_q;
  logic [TS_W-1:0] target_q;
  imu_sample_t     hold_q, oldest_q, data_q, prev_q, skid_q;
  logic            off_q, valid_q, miss_q, skid_full_q;

  logic            idle, early_miss, last_pair, ring_wr_en, wr_ok;
  imu_sample_t     sample_in_s, ring_wr_data, rd_data, oldest;
  logic [AW-1:0]   rd_age;
  logic [TS_W-1:0] newest_ts;
  logic [AW:0]     cnt;

  // Ring write source and scan addressing. A write landing on the request edge shifts ages
  // by one, so the scan skips that fresh entry via off_q.
  always_comb begin
    idle         = (state_q == StIdle);
    sample_in_s  = bus.sample_in;
    ring_wr_en   = idle && (skid_full_q || bus.sample_valid);
    ring_wr_data = skid_full_q ? skid_q : sample_in_s;
    rd_age       = (state_q == StScan) ? (j_q + AW'(1) + AW'(off_q)) : '0;
    early_miss   = (cnt < (AW+1)'(2)) || (bus.req_time > newest_ts) ||
                   (bus.req_time < oldest.ts);
    last_pair    = (j_q == last_j_q);
  end

  imu_sample_ring #(.DEPTH(DEPTH)) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (ring_wr_en),
    .wr_data   (ring_wr_data),
    .wr_ok     (wr_ok),
    .rd_age    (rd_age),
    .rd_data   (rd_data),
    .newest_ts (newest_ts),
    .oldest    (oldest),
    .cnt       (cnt),
    .drop_cnt  (bus.drop_cnt)
  );

  // Skid: capture while busy, release to the ring on the first idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_full_q <= 1'b0;
      skid_q      <= '0;
    end else if (idle) begin
      skid_full_q <= 1'b0;
    end else if (bus.sample_valid && !skid_full_q) begin
      skid_q      <= sample_in_s;
      skid_full_q <= 1'b1;
    end
  end

  // Search FSM with registered result pulses. The oldest entry is latched at request time
  // because a same-edge write into a full ring overwrites it; the last pair always hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      j_q      <= '0;
      last_j_q <= '0;
      off_q    <= 1'b0;
      target_q <= '0;
      hold_q   <= '0;
      oldest_q <= '0;
      data_q   <= '0;
      prev_q   <= '0;
      valid_q  <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      miss_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            target_q <= bus.req_time;
            if (early_miss) begin
              miss_q <= 1'b1;
            end else begin
              hold_q   <= rd_data;
              oldest_q <= oldest;
              last_j_q <= AW'(cnt - (AW+1)'(2));
              off_q    <= wr_ok;
              j_q      <= '0;
              state_q  <= StScan;
            end
          end
        end
        StScan: begin
          if (last_pair || (rd_data.ts <= target_q)) begin
            prev_q  <= last_pair ? oldest_q : rd_data;
            data_q  <= hold_q;
            valid_q <= 1'b1;
            state_q <= StEmit;
          end else begin
            hold_q <= rd_data;
            j_q    <= j_q + AW'(1);
          end
        end
        StEmit:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sample_ready   = !skid_full_q;
  assign bus.req_ready      = idle;
  assign bus.data_out       = data_q;
  assign bus.prev_out       = prev_q;
  assign bus.valid_out      = valid_q;
  assign bus.prev_valid_out = valid_q;
  assign bus.miss_out       = miss_q;

endmodule

// File: tb/tb_imu_bracket_finder.sv
// Bench for imu_bracket_finder: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_imu_bracket_finder;

  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   cmp_en = 1'b0;

  imu_bracket_finder_if bus ();

  imu_bracket_finder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [127:0] mq[$];
  logic [127:0] m_skid, p_data, p_prev, e_data, e_prev;
  bit           m_skid_v, e_valid, e_miss;
  int           m_busy;
  logic [15:0]  m_drop;

  task automatic commit(input logic [127:0] s);
    if (mq.size() > 0 && s[63:0] <= mq[mq.size()-1][63:0]) begin
      if (m_drop != 16'hFFFF) m_drop++;
    end else begin
      mq.push_back(s);
      if (mq.size() > DEPTH) void'(mq.pop_front());
    end
  endtask

  // Bracket = newest stored pair (k, k+1) with ts[k] <= t; search takes one cycle per pair.
  task automatic eval_req(input logic [63:0] t);
    int n, k;
    n = mq.size();
    if (n < 2) e_miss = 1'b1;
    else if (t > mq[n-1][63:0] || t < mq[0][63:0]) e_miss = 1'b1;
    else begin
      k = 0;
      for (int i = 0; i <= n - 2; i++) if (mq[i][63:0] <= t) k = i;
      p_prev = mq[k];
      p_data = mq[k+1];
      m_busy = n - k;  // (n-2-k) misses + hit cycle + emit cycle
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_skid_v = 1'b0; m_skid = '0; m_busy = 0; m_drop = '0;
      e_data = '0; e_prev = '0; e_valid = 1'b0; e_miss = 1'b0;
    end else begin
      e_valid = 1'b0;
      e_miss  = 1'b0;
      if (m_busy == 0) begin
        if (bus.req_valid) eval_req(bus.req_time);
        if (m_skid_v) begin
          commit(m_skid);
          m_skid_v = 1'b0;
        end else if (bus.sample_valid) commit(bus.sample_in);
      end else begin
        if (bus.sample_valid && !m_skid_v) begin
          m_skid = bus.sample_in;
          m_skid_v = 1'b1;
        end
        m_busy--;
        if (m_busy == 1) begin
          e_valid = 1'b1;
          e_data  = p_data;
          e_prev  = p_prev;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp("valid_out", bus.valid_out, e_valid);
      cmp("prev_valid_out", bus.prev_valid_out, e_valid);
      cmp("miss_out", bus.miss_out, e_miss);
      cmp("req_ready", bus.req_ready, m_busy == 0);
      cmp("sample_ready", bus.sample_ready, !m_skid_v);
      cmp("drop_cnt", bus.drop_cnt, m_drop);
      cmp("data_out", bus.data_out, e_data);
      cmp("prev_out", bus.prev_out, e_prev);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk); #1 rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic put_sample(input logic [63:0] ts, input logic [15:0] ax);
    bit rdy;
    rdy = 1'b0;
    bus.sample_in = {ax, 48'h0, ts};
    bus.sample_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      rdy = bus.sample_ready;
      @(negedge clk);
      if (rdy) break;
    end
    bus.sample_valid = 1'b0;
    if (!rdy) cmp("sample_accept", rdy, 1'b1);
  endtask

  task automatic wait_pulse(input int start, output int lat, output bit miss);
    lat = start;
    while (lat < 40 && !bus.valid_out && !bus.miss_out) begin
      @(negedge clk);
      lat++;
    end
    miss = bus.miss_out;
  endtask

  task automatic do_req(input logic [63:0] t, output int lat, output bit miss);
    for (int k = 0; k < 50 && !bus.req_ready; k++) @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_time  = t;
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_pulse(1, lat, miss);
  endtask

  task automatic chk_pair(input string tag, input logic [63:0] pts, input logic [15:0] pax,
                          input logic [63:0] dts, input logic [15:0] dax);
    cmp({tag, "_prev_ts"}, bus.prev_out[63:0], pts);
    cmp({tag, "_prev_ax"}, bus.prev_out[127:112], pax);
    cmp({tag, "_data_ts"}, bus.data_out[63:0], dts);
    cmp({tag, "_data_ax"}, bus.data_out[127:112], dax);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit miss, seen;
    logic [63:0] base;

    bus.sample_in = '0; bus.sample_valid = 1'b0;
    bus.req_valid = 1'b0; bus.req_time = '0;
    #1;
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;

    // Reset values
    cmp("rst_sample_ready", bus.sample_ready, 1'b1);
    cmp("rst_req_ready", bus.req_ready, 1'b1);
    cmp("rst_valid", bus.valid_out, 1'b0);
    cmp("rst_data", bus.data_out, 128'h0);
    cmp("rst_drop", bus.drop_cnt, 16'h0);

    // Single-entry ring: miss one cycle after acceptance
    put_sample(64'd50, 16'd7);
    do_req(64'd100, lat, miss);
    cmp("one_entry_miss", miss, 1'b1);
    cmp("one_entry_lat", lat, 1);

    // Bracketing on a four-entry ring
    do_reset();
    for (int i = 0; i < 4; i++) put_sample(64'(100 * (i + 1)), 16'(100 * i));
    do_req(64'd250, lat, miss);
    cmp("j1_hit", miss, 1'b0);
    cmp("j1_lat", lat, 3);
    chk_pair("j1", 64'd200, 16'd100, 64'd300, 16'd200);
    do_req(64'd400, lat, miss);
    cmp("newest_lat", lat, 2);
    chk_pair("newest", 64'd300, 16'd200, 64'd400, 16'd300);
    do_req(64'd450, lat, miss);
    cmp("above_miss", miss, 1'b1);
    cmp("above_lat", lat, 1);
    do_req(64'd50, lat, miss);
    cmp("below_miss", miss, 1'b1);
    cmp("below_lat", lat, 1);

    // Non-monotonic sample is dropped
    put_sample(64'd300, 16'd9);
    cmp("drop_one", bus.drop_cnt, 16'd1);

    // Sample arriving mid-search goes to the skid
    bus.req_valid = 1'b1; bus.req_time = 64'd150;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.sample_in = {16'd400, 48'h0, 64'd500}; bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    cmp("skid_full_ready", bus.sample_ready, 1'b0);
    wait_pulse(2, lat, miss);
    cmp("skid_search_lat", lat, 4);
    chk_pair("skid_search", 64'd100, 16'd0, 64'd200, 16'd100);
    repeat (2) @(negedge clk);
    do_req(64'd450, lat, miss);
    cmp("after_skid_lat", lat, 2);
    chk_pair("after_skid", 64'd400, 16'd300, 64'd500, 16'd400);

    // Wrap and overwrite
    do_reset();
    for (int i = 1; i <= 10; i++) put_sample(64'(10 * i), 16'(i));
    do_req(64'd25, lat, miss);
    cmp("wrap_miss", miss, 1'b1);
    do_req(64'd35, lat, miss);
    cmp("wrap_lat", lat, 8);
    chk_pair("wrap", 64'd30, 16'd3, 64'd40, 16'd4);

    // Reset in the middle of a search
    bus.req_valid = 1'b1; bus.req_time = 64'd35;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.valid_out || bus.miss_out) seen = 1'b1;
    end
    cmp("midscan_no_pulse", seen, 1'b0);
    cmp("midscan_data", bus.data_out, 128'h0);
    do_req(64'd35, lat, miss);
    cmp("midscan_ring_empty", miss, 1'b1);

    // Randomized traffic against the model
    base = 64'd1000;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      base += 64'($urandom_range(0, 20));
      bus.sample_valid = ($urandom_range(0, 1) == 1);
      bus.sample_in = {$urandom(), $urandom(), ($urandom_range(0, 9) == 0) ? base - 64'd30 : base};
      bus.req_valid = ($urandom_range(0, 3) == 0);
      bus.req_time  = base + 64'd15 - 64'($urandom_range(0, 250));
    end
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.req_valid = 1'b0;
    repeat (DEPTH + 4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imu_bracket_finder.md
# imu_bracket_finder

Upstream stage of the IMU synchronizer timestamp interpolator. Keeps a ring of the most recent timestamped IMU samples. On a fusion-side request for a target time, it searches for the two consecutive samples that bracket that time. It then presents the pair (older on `prev_out`, newer on `data_out`) together with matching valid strobes in the exact 128-bit packing the interpolator consumes, or flags a miss.

## Interface
- `DEPTH`, 8 — ring entries; power of two, ≥4.
- `TS_W`, 64 — timestamp width. Fixed at 64 for this packing.
- `clk` in 1 — single clock; all logic on its rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `sample_in` in 128 — `[127:64]` = {ax, ay, az, gx}, signed 16-bit each, ax in the MSBs; `[63:0]` = timestamp.
- `sample_valid` in 1 — sample offered.
- `sample_ready` out 1 — sample accepted when `sample_valid && sample_ready`.
- `req_valid` in 1 — interpolation request.
- `req_time` in 64 — target timestamp.
- `req_ready` out 1 — high only in IDLE.
- `data_out` out 128 — newer bracketing sample.
- `valid_out` out 1 — one-cycle pulse; `data_out` valid.
- `prev_out` out 128 — older bracketing sample.
- `prev_valid_out` out 1 — one-cycle pulse, always coincident with `valid_out`.
- `miss_out` out 1 — one-cycle pulse; no bracket exists for the request.
- `drop_cnt` out 16 — saturating count of rejected non-monotonic samples.

## Operation
- **Ring:** write pointer `wp` and occupancy `cnt` (0..DEPTH, saturates).
  - Each accepted sample is written at `wp`, then `wp` increments and wraps mod DEPTH.
  - When full, the oldest entry is overwritten.
- **Monotonic check:** an accepted sample whose timestamp is ≤ the newest stored timestamp (with `cnt > 0`) is not written, and `drop_cnt` increments, saturating at 0xFFFF. Stored timestamps are therefore strictly increasing, so the interpolator never sees t2 == t1.
- **FSM states:** IDLE, SCAN, EMIT.
  - **IDLE:** `req_ready = 1`. On `req_valid`, latch `req_time` and run the early-miss check:
    - `cnt < 2`, or `req_time > newest ts`, or `req_time < oldest ts` → pulse `miss_out` and stay in IDLE.
    - Otherwise go to SCAN with `j = 0`.
  - **SCAN:** one pair per cycle. Pair j = (entry newest−j−1, entry newest−j).
    - If `ts(newest−j−1) ≤ target`, the pair is a hit: latch it and go to EMIT.
    - Otherwise increment `j`. A hit is guaranteed by `j = cnt − 2`.
  - **EMIT:** drive `prev_out`/`data_out`, pulse `valid_out` and `prev_valid_out`, return to IDLE.
- **Exact matches:** `target == newest ts` hits at `j = 0`, producing ratio 1.0 downstream. `target == oldest ts` hits on the last pair.
- **Sample skid:** a one-entry skid register protects ring contents during a search.
  - In SCAN/EMIT, an accepted sample goes into the skid instead of the ring.
  - `sample_ready = !skid_full`.
  - The skid commits to the ring, with the monotonic check applied, on the first IDLE cycle. In that cycle `sample_ready` stays low.
- **Simultaneous events in IDLE:** a request and a sample write in the same cycle are both accepted. The request evaluates against the ring contents before the write.

## Timing
- A request accepted at edge E0 produces:
  - early miss: `miss_out` high in the cycle after E0;
  - hit at pair j: `valid_out` high in cycle E0 + j + 2;
  - worst case: E0 + DEPTH.
- `valid_out`, `prev_valid_out` and `miss_out` are registered, last exactly one cycle, and are mutually exclusive with each other except that `valid_out` and `prev_valid_out` always pulse together.
- `data_out` and `prev_out` hold their last value between pulses.
- **Reset values:** all outputs 0 except `sample_ready` = 1 and `req_ready` = 1. `cnt`, `wp`, skid, `drop_cnt` and FSM are cleared (FSM → IDLE).
- **Reset mid-SCAN:** the request is abandoned with no pulse, and ring contents are discarded.

## Structure
- **Package `imu_sync_pkg`:**
  - `imu_data_t` packed struct {ax, ay, az, gx}, signed 16-bit each;
  - `imu_sample_t` {imu_data_t payload, 64-bit ts};
  - constants `SAMPLE_W = 128` and `TS_W = 64`;
  - FSM state enum.
- **Sub-module `imu_sample_ring`:** storage, `wp`, `cnt`, monotonic check and `drop_cnt`, with one read port addressed by age (0 = newest). The top level holds the FSM and skid.

## Test plan
- **Empty ring:** ring holds one sample; request at t = 100 → `miss_out` pulse one cycle after acceptance, no `valid_out`.
- **Hit at j = 1:** samples ts 100/200/300/400 with ax = 0/100/200/300; request 250 → j = 1 hit.
  - `prev_out` ts = 200, ax = 100; `data_out` ts = 300, ax = 200.
  - `valid_out` and `prev_valid_out` high at E0 + 3.
- **Out-of-range requests:** same ring; request 400 → pair (300, 400) at E0 + 2. Requests 450 and 50 → `miss_out` at E0 + 1.
- **Wrap and overwrite:** DEPTH = 8, write 10 samples ts 10..100 step 10. Request 25 → miss (oldest is 30). Request 35 → pair (30, 40) at E0 + 8.
- **Skid under load:** write ts 500 during SCAN → `sample_ready` drops, sample committed after EMIT. A following request of 450 brackets (400, 500).
- **Drops and reset:** sample ts 300 after 400 → `drop_cnt` = 1, ring unchanged. Assert `rst_n` low mid-SCAN → all outputs at reset values, no pulse afterwards.
